data_mem_unit: RTL and testbench
================================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning byte-address bits; memory depth is 2**ADDR_WIDTH bytes.
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles between accept and response; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_error, output, 1 bit: request rejected, no memory effect.

Function
REQ-015 SHALL use byte storage, big-endian: the byte at addr is bits [31:24] of a word and bits [15:8] of a half.
REQ-016 SHALL use FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL, on req_valid&&req_ready at a rising edge, latch all req_* fields and go to WAIT with counter = LATENCY-1, or straight to RESP if LATENCY = 0.
REQ-018 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-019 SHALL, on the edge entering RESP, commit the store, or sample load data from the array state that exists before that edge.
REQ-020 SHALL hold resp_valid = 1 for exactly the RESP cycle, then return to IDLE on the next edge with no backpressure.
REQ-021 SHALL keep resp_rdata and resp_error registered, held until the next response, and change only on the edge entering RESP.
REQ-022 SHALL set the error condition when req_size = 11, when a half is at an odd address, when a word has addr[1:0] != 0, or when addr[31:ADDR_WIDTH] != 0.
REQ-023 SHALL, on error, perform no write, drive resp_rdata = 0 and resp_error = 1, with the same latency as a good access.
REQ-024 SHALL have a byte store write 1 byte, a half store 2 bytes and a word store 4 bytes, leaving other bytes unchanged.
REQ-025 SHALL extend byte and half loads to 32 bits per the latched req_unsigned; word loads are unaffected by req_unsigned.
REQ-026 SHALL ignore req_* while not in IDLE.
REQ-027 SHALL give throughput of one transaction per LATENCY+2 cycles.

Reset
REQ-028 SHALL, on rst_n low, immediately force IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0 and resp_error 0.
REQ-029 SHALL, on reset during WAIT, discard the transaction, perform no write and produce no response.
REQ-030 SHALL NOT clear or initialise array contents on reset.

Verification
REQ-031 SHALL cover: LATENCY=1, word store 0x0F0A0F07 at 4, then word load at 4 -> resp_valid 2 cycles after each accept, rdata 0x0F0A0F07, error 0.
REQ-032 SHALL cover: after REQ-031, byte loads at 5 signed and unsigned -> 0x0000000A both; then byte store 0xFF at 8 and signed byte load at 8 -> 0xFFFFFFFF, unsigned -> 0x000000FF.
REQ-033 SHALL cover: word 0x0011FF01 at 8, then half load at 10 signed -> 0xFFFFFF01, unsigned -> 0x0000FF01, half load at 8 -> 0x00000011.
REQ-034 SHALL cover: word load at 6, half store at 9, access at 0x200 (ADDR_WIDTH=9) and size 11 -> each resp_error 1, rdata 0, memory unchanged on readback.
REQ-035 SHALL cover: LATENCY=3, store accepted, rst_n pulsed low during WAIT -> no resp_valid, word unchanged on readback, req_ready 1 immediately.
REQ-036 SHALL cover: LATENCY=0 with req_valid held high for 10 cycles -> 5 accepts, resp_valid alternating 0/1, req_ready alternating 1/0.

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed, big-endian data memory with a fixed-latency
// request/response handshake.
//
// Parameters
//   ADDR_WIDTH : byte-address bits, memory holds 2**ADDR_WIDTH bytes
//   LATENCY    : wait cycles between accept and response (0..15)
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid / req_ready      : request handshake (ready only when idle)
//   req_write                  : 1 = store, 0 = load
//   req_size                   : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned               : zero-extend (1) or sign-extend (0) loads
//   req_addr, req_wdata        : byte address, right-aligned store data
//   resp_valid                 : one-cycle response pulse
//   resp_rdata, resp_error     : registered load data / rejection flag
module data_mem_unit #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] Off1 = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] Off2 = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] Off3 = ADDR_WIDTH'(3);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e r_state, w_state_next;
  logic [3:0] r_cnt;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [7:0] r_mem [Depth];

  logic w_accept;
  logic w_enter_resp;
  assign w_accept = req_valid && (r_state == StIdle);
  // Gated by rst_n so a zero-latency request seen during reset cannot write.
  assign w_enter_resp = rst_n && (w_state_next == StResp) && (r_state != StResp);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_state_next = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (r_state == StIdle);
    resp_valid = (r_state == StResp);
  end

  // Wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CntInit;
    end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // With LATENCY = 0 the RESP edge is the accept edge, so the live request
  // fields must be used while idle; otherwise the latched copy.
  logic        w_cur_write;
  logic [1:0]  w_cur_size;
  logic        w_cur_unsigned;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  always_comb begin
    if (r_state == StIdle) begin
      w_cur_write    = req_write;
      w_cur_size     = req_size;
      w_cur_unsigned = req_unsigned;
      w_cur_addr     = req_addr;
      w_cur_wdata    = req_wdata;
    end else begin
      w_cur_write    = r_write;
      w_cur_size     = r_size;
      w_cur_unsigned = r_unsigned;
      w_cur_addr     = r_addr;
      w_cur_wdata    = r_wdata;
    end
  end

  // Error detection
  logic w_err;
  always_comb begin
    w_err = 1'b0;
    if (w_cur_size == 2'b11) w_err = 1'b1;
    if ((w_cur_size == 2'b01) && w_cur_addr[0]) w_err = 1'b1;
    if ((w_cur_size == 2'b10) && (w_cur_addr[1:0] != 2'b00)) w_err = 1'b1;
    if ((w_cur_addr >> ADDR_WIDTH) != 32'd0) w_err = 1'b1;
  end

  // Big-endian lane addressing: the byte at idx is the most significant.
  logic [ADDR_WIDTH-1:0] w_idx0, w_idx1, w_idx2, w_idx3;
  assign w_idx0 = w_cur_addr[ADDR_WIDTH-1:0];
  assign w_idx1 = w_idx0 + Off1;
  assign w_idx2 = w_idx0 + Off2;
  assign w_idx3 = w_idx0 + Off3;

  logic [31:0] w_load;
  always_comb begin
    w_load = 32'd0;
    unique case (w_cur_size)
      2'b00: begin
        w_load = w_cur_unsigned ? {24'd0, r_mem[w_idx0]}
                                : {{24{r_mem[w_idx0][7]}}, r_mem[w_idx0]};
      end
      2'b01: begin
        w_load = w_cur_unsigned ? {16'd0, r_mem[w_idx0], r_mem[w_idx1]}
                                : {{16{r_mem[w_idx0][7]}}, r_mem[w_idx0], r_mem[w_idx1]};
      end
      2'b10: w_load = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
      default: w_load = 32'd0;
    endcase
  end

  // Array write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_cur_write && !w_err) begin
      unique case (w_cur_size)
        2'b00: r_mem[w_idx0] <= w_cur_wdata[7:0];
        2'b01: begin
          r_mem[w_idx0] <= w_cur_wdata[15:8];
          r_mem[w_idx1] <= w_cur_wdata[7:0];
        end
        2'b10: begin
          r_mem[w_idx0] <= w_cur_wdata[31:24];
          r_mem[w_idx1] <= w_cur_wdata[23:16];
          r_mem[w_idx2] <= w_cur_wdata[15:8];
          r_mem[w_idx3] <= w_cur_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Response registers, updated only on the edge entering RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else if (w_enter_resp) begin
      resp_rdata <= (w_cur_write || w_err) ? 32'd0 : w_load;
      resp_error <= w_err;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared request fields; per-instance valid and reset.
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  vld;
  logic [2:0]  rstn;

  logic [2:0]  rdy, rv, rerr;
  logic [31:0] rdata [3];

  // Instance 0: LATENCY=1, 1: LATENCY=3, 2: LATENCY=0
  data_mem_unit #(.ADDR_WIDTH(9), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rstn[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[0]),
    .resp_rdata(rdata[0]), .resp_error(rerr[0])
  );
  data_mem_unit #(.ADDR_WIDTH(9), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rstn[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[1]),
    .resp_rdata(rdata[1]), .resp_error(rerr[1])
  );
  data_mem_unit #(.ADDR_WIDTH(9), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rstn[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv[2]),
    .resp_rdata(rdata[2]), .resp_error(rerr[2])
  );

  int checks = 0;
  int failures = 0;
  int sel = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance sel, checking timing and response.
  task automatic txn(input string tag, input int lat, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    vld[sel]     = 1'b1;
    @(posedge clk); #1;
    vld[sel]     = 1'b0;
    // Scramble inputs: they must be ignored after accept.
    req_write = ~wr; req_addr = 32'h0000_0100; req_wdata = 32'hA5A5_A5A5;
    req_size = 2'b00; req_unsigned = ~uns;
    for (int i = 0; i < lat; i++) begin
      chk({tag, ".wait_valid"}, {31'd0, rv[sel]}, 32'd0);
      chk({tag, ".wait_ready"}, {31'd0, rdy[sel]}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, ".resp_valid"}, {31'd0, rv[sel]}, 32'd1);
    chk({tag, ".rdata"}, rdata[sel], exp_rd);
    chk({tag, ".error"}, {31'd0, rerr[sel]}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, {31'd0, rv[sel]}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, rdy[sel]}, 32'd1);
    chk({tag, ".rdata_held"}, rdata[sel], exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    vld  = 3'b000;
    rstn = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'd0, rdy[0]}, 32'd1);
    chk("rst.valid", {31'd0, rv[0]}, 32'd0);
    chk("rst.rdata", rdata[0], 32'd0);
    chk("rst.error", {31'd0, rerr[0]}, 32'd0);
    rstn = 3'b111;
    @(posedge clk); #1;

    // ---- LATENCY = 1 ----
    sel = 0;
    txn("sw4",     1, 1'b1, 2'b10, 1'b0, 32'd4,  32'h0F0A0F07, 32'h0, 1'b0);
    txn("lw4",     1, 1'b0, 2'b10, 1'b0, 32'd4,  32'h0,        32'h0F0A0F07, 1'b0);
    txn("lb5s",    1, 1'b0, 2'b00, 1'b0, 32'd5,  32'h0,        32'h0000000A, 1'b0);
    txn("lb5u",    1, 1'b0, 2'b00, 1'b1, 32'd5,  32'h0,        32'h0000000A, 1'b0);
    txn("sb8",     1, 1'b1, 2'b00, 1'b0, 32'd8,  32'h000000FF, 32'h0, 1'b0);
    txn("lb8s",    1, 1'b0, 2'b00, 1'b0, 32'd8,  32'h0,        32'hFFFFFFFF, 1'b0);
    txn("lb8u",    1, 1'b0, 2'b00, 1'b1, 32'd8,  32'h0,        32'h000000FF, 1'b0);
    txn("sw8",     1, 1'b1, 2'b10, 1'b0, 32'd8,  32'h0011FF01, 32'h0, 1'b0);
    txn("lh10s",   1, 1'b0, 2'b01, 1'b0, 32'd10, 32'h0,        32'hFFFFFF01, 1'b0);
    txn("lh10u",   1, 1'b0, 2'b01, 1'b1, 32'd10, 32'h0,        32'h0000FF01, 1'b0);
    txn("lh8s",    1, 1'b0, 2'b01, 1'b0, 32'd8,  32'h0,        32'h00000011, 1'b0);
    // Error cases
    txn("err.lw6",   1, 1'b0, 2'b10, 1'b0, 32'd6,     32'h0,        32'h0, 1'b1);
    txn("err.sh9",   1, 1'b1, 2'b01, 1'b0, 32'd9,     32'h0000BEEF, 32'h0, 1'b1);
    txn("err.sw200", 1, 1'b1, 2'b10, 1'b0, 32'h200,   32'hDEADBEEF, 32'h0, 1'b1);
    txn("err.sz11",  1, 1'b1, 2'b11, 1'b0, 32'd4,     32'h11223344, 32'h0, 1'b1);
    txn("err.lsz11", 1, 1'b0, 2'b11, 1'b0, 32'd4,     32'h0,        32'h0, 1'b1);
    // Memory unchanged by rejected accesses (0x200 must not alias to 0)
    txn("rb.w8",   1, 1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 32'h0011FF01, 1'b0);
    txn("rb.w4",   1, 1'b0, 2'b10, 1'b0, 32'd4,  32'h0, 32'h0F0A0F07, 1'b0);
    txn("sw0",     1, 1'b1, 2'b10, 1'b0, 32'd0,  32'h01020304, 32'h0, 1'b0);
    txn("err.lw200", 1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    txn("rb.w0",   1, 1'b0, 2'b10, 1'b0, 32'd0,  32'h0, 32'h01020304, 1'b0);

    // ---- LATENCY = 3, reset during WAIT ----
    sel = 1;
    txn("l3.sw0",  3, 1'b1, 2'b10, 1'b0, 32'd0, 32'h12345678, 32'h0, 1'b0);
    txn("l3.lw0",  3, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0,        32'h12345678, 1'b0);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'hDEADBEEF;
    vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    chk("l3.in_wait", {31'd0, rdy[1]}, 32'd0);
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    chk("l3.rst_ready", {31'd0, rdy[1]}, 32'd1);
    chk("l3.rst_valid", {31'd0, rv[1]}, 32'd0);
    chk("l3.rst_rdata", rdata[1], 32'd0);
    #2;
    rstn[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("l3.no_resp", {31'd0, rv[1]}, 32'd0);
    end
    txn("l3.rb", 3, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 32'h12345678, 1'b0);

    // ---- LATENCY = 0, back-to-back ----
    sel = 2;
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd12; req_wdata = 32'hCAFEF00D;
    acc = 0;
    vld[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rdy[2]) acc++;
      @(posedge clk); #1;
      chk($sformatf("l0.valid%0d", i), {31'd0, rv[2]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("l0.ready%0d", i), {31'd0, rdy[2]}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    vld[2] = 1'b0;
    chk("l0.accepts", acc, 32'd5);
    txn("l0.lw12", 0, 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 32'hCAFEF00D, 1'b0);
    txn("l0.lh14u", 0, 1'b0, 2'b01, 1'b1, 32'd14, 32'h0, 32'h0000F00D, 1'b0);
    txn("l0.lb12s", 0, 1'b0, 2'b00, 1'b0, 32'd12, 32'h0, 32'hFFFFFFCA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
